// File: rtl/demux_14_tdm_if.sv
// demux_14_tdm_if -- bus bundle for the TDM 1:4 demultiplexer.
//   master : serial sample source (drives in_valid, sync, d; observes frame)
//   slave  : the demultiplexer (receives samples; drives y0..y3, sel,
//            frame_valid and, when DEMUX_SYNC_ERR_EN is defined, sync_err)
// Optional macro: DEMUX_SYNC_ERR_EN adds the sync_err status line.
interface demux_14_tdm_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic             sync;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [1:0]       sel;
  logic             frame_valid;
`ifdef DEMUX_SYNC_ERR_EN
  logic             sync_err;

  modport master (output in_valid, sync, d,
                  input  y0, y1, y2, y3, sel, frame_valid, sync_err);
  modport slave  (input  in_valid, sync, d,
                  output y0, y1, y2, y3, sel, frame_valid, sync_err);
`else
  modport master (output in_valid, sync, d,
                  input  y0, y1, y2, y3, sel, frame_valid);
  modport slave  (input  in_valid, sync, d,
                  output y0, y1, y2, y3, sel, frame_valid);
`endif
endinterface

// File: rtl/demux_14_tdm.sv
// demux_14_tdm -- time-division 1:4 demultiplexer.
// Steers each valid serial sample into slot sel = {A,B} (A = MSB) and
// publishes all four slots together as y0..y3 with a one-cycle frame_valid
// pulse when slot 3 arrives. sync forces the current sample to slot 0.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_14_tdm_if.slave (in_valid, sync, d -> y0..y3, sel,
//           frame_valid[, sync_err])
// Optional macro: DEMUX_SYNC_ERR_EN -- sync_err pulses one cycle after any
// edge that saw sync while a frame was partially assembled (sel != 0).
module demux_14_tdm #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_14_tdm_if.slave  bus
);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  slot_e                 slot_q, slot_d;
  // Slots 0..2 wait here until slot 3 completes the frame.
  logic [2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0][WIDTH-1:0] chan_q, chan_d;
  logic                  fv_q, fv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= SLOT0;
      shadow_q <= '0;
      chan_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      chan_q   <= chan_d;
      fv_q     <= fv_d;
    end
  end

  always_comb begin
    slot_d   = slot_q;
    shadow_d = shadow_q;
    chan_d   = chan_q;
    fv_d     = 1'b0;
    if (bus.sync && bus.in_valid) begin
      // Realign: this sample is slot 0 whatever the counter said.
      shadow_d[0] = bus.d;
      slot_d      = SLOT1;
    end else if (bus.sync) begin
      // Abandon the partial frame; stale shadows get overwritten later.
      slot_d = SLOT0;
    end else if (bus.in_valid) begin
      if (slot_q == SLOT3) begin
        // Slot 3 goes straight to y3 so the frame publishes this edge.
        chan_d = {bus.d, shadow_q[2], shadow_q[1], shadow_q[0]};
        fv_d   = 1'b1;
        slot_d = SLOT0;
      end else begin
        for (int i = 0; i < 3; i++)
          if (int'(slot_q) == i) shadow_d[i] = bus.d;
        slot_d = slot_e'(slot_q + 2'd1);
      end
    end
  end

  assign bus.y0          = chan_q[0];
  assign bus.y1          = chan_q[1];
  assign bus.y2          = chan_q[2];
  assign bus.y3          = chan_q[3];
  assign bus.sel         = slot_q;
  assign bus.frame_valid = fv_q;

`ifdef DEMUX_SYNC_ERR_EN
  logic se_q;

  // Flags both sync+valid and sync-only realigns that cut a frame short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) se_q <= 1'b0;
    else        se_q <= bus.sync && (slot_q != SLOT0);
  end

  assign bus.sync_err = se_q;
`endif

endmodule

// File: tb/tb_demux_14_tdm.sv
// tb_demux_14_tdm -- self-checking bench for demux_14_tdm (WIDTH = 4).
// Reference model: the partially assembled frame is a queue of samples;
// sel is its length, a full queue of four becomes the published frame.
module tb_demux_14_tdm;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_14_tdm_if #(.WIDTH(W)) bus ();
  demux_14_tdm #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [W-1:0] fq [$];
  logic [W-1:0] exp_y [4];
  logic [1:0]   exp_sel;
  logic         exp_fv;
  logic         exp_se;

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < 4; i++) exp_y[i] = '0;
    exp_sel = '0;
    exp_fv  = 1'b0;
    exp_se  = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic s, input logic [W-1:0] dd);
    exp_se = s && (fq.size() != 0);
    exp_fv = 1'b0;
    if (s) begin
      fq.delete();
      if (v) fq.push_back(dd);
    end else if (v) begin
      fq.push_back(dd);
      if (fq.size() == 4) begin
        for (int i = 0; i < 4; i++) exp_y[i] = fq[i];
        exp_fv = 1'b1;
        fq.delete();
      end
    end
    exp_sel = 2'(fq.size());
  endtask

  // Present one cycle of input, clock it, update the model, then sample
  // outputs 1 time unit after the edge. Inputs return to idle afterwards.
  task automatic step(input logic v, input logic s, input logic [W-1:0] dd);
    bus.in_valid = v;
    bus.sync     = s;
    bus.d        = dd;
    @(posedge clk);
    model_edge(v, s, dd);
    #1;
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
  endtask

  function automatic logic [15:0] y_all();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  task automatic test_reset();
    logic [15:0] ys;
    bus.in_valid = 1'b0; bus.sync = 1'b0; bus.d = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({y_all(), bus.sel, bus.frame_valid} !== 19'd0) begin
      nerr++; $display("FAIL reset_init: got y=%h sel=%0d fv=%b, want all 0", y_all(), bus.sel, bus.frame_valid);
    end
    rst_n = 1'b1;
    // Fill a frame so outputs are nonzero, then leave a partial frame open.
    step(1, 1, 4'($urandom_range(1, 15)));
    for (int k = 0; k < 3; k++) step(1, 0, 4'($urandom_range(1, 15)));
    step(1, 0, 4'($urandom)); step(1, 0, 4'($urandom));
    ys = y_all();
    nvec++;
    if (ys === 16'd0 || bus.sel !== 2'd2) begin
      nerr++; $display("FAIL reset_prefill: got y=%h sel=%0d, want y!=0 sel=2", ys, bus.sel);
    end
    #1 rst_n = 1'b0;   // between edges: must act without a clock
    bus.d = 4'($urandom);
    #1;
    nvec++;
    if ({y_all(), bus.sel, bus.frame_valid} !== 19'd0) begin
      nerr++; $display("FAIL reset_async: got y=%h sel=%0d fv=%b, want all 0", y_all(), bus.sel, bus.frame_valid);
    end
`ifdef DEMUX_SYNC_ERR_EN
    nvec++;
    if (bus.sync_err !== 1'b0) begin
      nerr++; $display("FAIL reset_sync_err: got %b want 0", bus.sync_err);
    end
`endif
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step(1, 1, 4'd1);
    nvec++;
    if (bus.sel !== 2'd1) begin nerr++; $display("FAIL basic_sel1: got %0d want 1", bus.sel); end
    step(1, 0, 4'd2);
    step(1, 0, 4'd3);
    nvec++;
    if (bus.frame_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_fv: got %b want 0", bus.frame_valid); end
    step(1, 0, 4'd4);
    nvec++;
    if ({y_all(), bus.sel, bus.frame_valid} !== {16'h4321, 2'd0, 1'b1}) begin
      nerr++; $display("FAIL basic_frame: got y=%h sel=%0d fv=%b, want y=4321 sel=0 fv=1", y_all(), bus.sel, bus.frame_valid);
    end
    step(0, 0, 4'd0);
    nvec++;
    if ({y_all(), bus.frame_valid} !== {16'h4321, 1'b0}) begin
      nerr++; $display("FAIL basic_pulse: got y=%h fv=%b, want y=4321 fv=0", y_all(), bus.frame_valid);
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    step(1, 1, 4'd5); pulses += int'(bus.frame_valid);
    step(1, 0, 4'd6); pulses += int'(bus.frame_valid);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 4'($urandom));
      pulses += int'(bus.frame_valid);
      nvec++;
      if (bus.sel !== 2'd2) begin nerr++; $display("FAIL stall_sel: gap %0d got %0d want 2", k, bus.sel); end
    end
    step(1, 0, 4'd7); pulses += int'(bus.frame_valid);
    step(1, 0, 4'd8); pulses += int'(bus.frame_valid);
    nvec++;
    if ({y_all(), bus.sel} !== {16'h8765, 2'd0}) begin
      nerr++; $display("FAIL stall_frame: got y=%h sel=%0d, want y=8765 sel=0", y_all(), bus.sel);
    end
    step(0, 0, 4'd0); pulses += int'(bus.frame_valid);
    nvec++;
    if (pulses !== 1) begin nerr++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_realign();
    step(1, 1, 4'd13);
    step(1, 0, 4'd14);
    step(1, 1, 4'd9);
    nvec++;
    if ({bus.frame_valid, bus.sel, bus.y0} !== {1'b0, 2'd1, 4'd5}) begin
      nerr++; $display("FAIL realign_sync: got fv=%b sel=%0d y0=%0d, want fv=0 sel=1 y0=5", bus.frame_valid, bus.sel, bus.y0);
    end
`ifdef DEMUX_SYNC_ERR_EN
    nvec++;
    if (bus.sync_err !== 1'b1) begin nerr++; $display("FAIL realign_err: got %b want 1", bus.sync_err); end
`endif
    step(1, 0, 4'd10);
`ifdef DEMUX_SYNC_ERR_EN
    nvec++;
    if (bus.sync_err !== 1'b0) begin nerr++; $display("FAIL realign_err_pulse: got %b want 0", bus.sync_err); end
`endif
    step(1, 0, 4'd11);
    nvec++;
    if (bus.frame_valid !== 1'b0) begin nerr++; $display("FAIL realign_early_fv: got %b want 0", bus.frame_valid); end
    step(1, 0, 4'd12);
    nvec++;
    if ({y_all(), bus.frame_valid} !== {16'hCBA9, 1'b1}) begin
      nerr++; $display("FAIL realign_frame: got y=%h fv=%b, want y=cba9 fv=1", y_all(), bus.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      step(1, k == 0, 4'(k));
      nvec++;
      if (bus.frame_valid !== ((k % 4) == 3)) begin
        nerr++; $display("FAIL b2b_fv: sample %0d got %b want %b", k, bus.frame_valid, (k % 4) == 3);
      end
    end
    nvec++;
    if (y_all() !== 16'hBA98) begin nerr++; $display("FAIL b2b_last: got %h want ba98", y_all()); end
    repeat (5) step(0, 0, 4'($urandom));
    nvec++;
    if ({y_all(), bus.frame_valid, bus.sel} !== {16'hBA98, 1'b0, 2'd0}) begin
      nerr++; $display("FAIL b2b_hold: got y=%h fv=%b sel=%0d, want y=ba98 fv=0 sel=0", y_all(), bus.frame_valid, bus.sel);
    end
  endtask

  task automatic test_sync_only();
    step(1, 1, 4'd1);
    step(1, 0, 4'd2);
    nvec++;
    if (bus.sel !== 2'd2) begin nerr++; $display("FAIL synconly_pre: sel got %0d want 2", bus.sel); end
    step(0, 1, 4'd7);
    nvec++;
    if ({bus.sel, bus.frame_valid, y_all()} !== {2'd0, 1'b0, 16'hBA98}) begin
      nerr++; $display("FAIL synconly: got sel=%0d fv=%b y=%h, want sel=0 fv=0 y=ba98", bus.sel, bus.frame_valid, y_all());
    end
`ifdef DEMUX_SYNC_ERR_EN
    nvec++;
    if (bus.sync_err !== 1'b1) begin nerr++; $display("FAIL synconly_err: got %b want 1", bus.sync_err); end
    step(0, 1, 4'd0);   // sync at sel=0 never flags
    nvec++;
    if (bus.sync_err !== 1'b0) begin nerr++; $display("FAIL synconly_sel0: got %b want 0", bus.sync_err); end
`endif
  endtask

  task automatic test_random();
    logic v, s;
    logic [W-1:0] dd;
    for (int k = 0; k < 400; k++) begin
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) == 0);
      dd = 4'($urandom);
      step(v, s, dd);
      nvec++;
      if ({y_all(), bus.sel, bus.frame_valid} !==
          {exp_y[3], exp_y[2], exp_y[1], exp_y[0], exp_sel, exp_fv}) begin
        nerr++;
        $display("FAIL random[%0d]: got y=%h sel=%0d fv=%b, want y=%h%h%h%h sel=%0d fv=%b",
                 k, y_all(), bus.sel, bus.frame_valid,
                 exp_y[3], exp_y[2], exp_y[1], exp_y[0], exp_sel, exp_fv);
      end
`ifdef DEMUX_SYNC_ERR_EN
      nvec++;
      if (bus.sync_err !== exp_se) begin
        nerr++; $display("FAIL random_err[%0d]: got %b want %b", k, bus.sync_err, exp_se);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_realign();
    test_back_to_back();
    test_sync_only();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/demux_14_tdm.md
Name: demux_14_tdm

Overview:
- Time-division 1:4 demultiplexer; the receive-side counterpart of the 4:1 mux tree.
- Takes one serial sample stream, steers each valid sample into one of four channel slots using an internal 2-bit slot counter, and publishes all four channels together as one frame.
- Sits after a TDM 4:1 mux link and recovers i0..i3 as y0..y3, with the same select coding: slot = {A,B}, A = MSB.

Parameters:
WIDTH, 1, bit width of each sample and of each channel output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  d carries a valid sample this cycle.
sync  input  1  frame alignment; marks the current/next sample as slot 0.
d  input  WIDTH  serial sample input.
y0  output  WIDTH  channel 0 (slot {A,B}=00), registered.
y1  output  WIDTH  channel 1 (slot 01), registered.
y2  output  WIDTH  channel 2 (slot 10), registered.
y3  output  WIDTH  channel 3 (slot 11), registered.
sel  output  2  current slot counter; sel[1]=A, sel[0]=B.
frame_valid  output  1  one-cycle pulse: y0..y3 updated with a complete frame.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low, and is released synchronously by the integrator.
  - Reset values: sel=0, y0..y3=0, frame_valid=0, shadow registers s0..s2=0.
- State: the slot counter sel cycles 0->1->2->3->0. Per rising edge, first match wins:
  - 1. sync=1 and in_valid=1: s0<=d, sel<=1. The sample is slot 0 regardless of the old sel.
  - 2. sync=1 and in_valid=0: sel<=0. The partial frame is abandoned; shadow contents are left unchanged and are overwritten later.
  - 3. in_valid=1 and sel in {0,1,2}: s[sel]<=d, sel<=sel+1.
  - 4. in_valid=1 and sel=3: y0<=s0, y1<=s1, y2<=s2, y3<=d, all in the same edge. Also frame_valid<=1 and sel<=0 (wrap-around).
  - 5. Otherwise: hold all state.
- frame_valid:
  - It is 0 on every edge where case 4 does not fire, so it is a single-cycle pulse.
  - Back-to-back frames with continuous in_valid give frame_valid high once every 4 cycles.
- Latency: y3 shows the slot-3 sample 1 clock after it is presented. y0..y3 change only in case 4, so they hold the last complete frame indefinitely.
- Gaps: in_valid low between samples just stalls; sel holds and no timeout applies.
- sync with sel=3 and in_valid=1 follows case 1: no frame is published, and the sample becomes slot 0.
- Reset mid-frame: shadows and outputs clear immediately. The next valid sample is slot 0.
- No arithmetic beyond the 2-bit modulo-4 increment.

Optional Feature:
- Macro: DEMUX_SYNC_ERR_EN.
- Defined:
  - Adds output port sync_err (1 bit, reset 0).
  - sync_err pulses high for one cycle after any edge where sync=1 while sel!=0, i.e. misaligned or truncated frame. This is evaluated for both case 1 and case 2.
  - sync with sel=0 never flags.
- Undefined: the port does not exist, and sync realigns silently. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-stream with random d -> y0..y3=0, sel=0, frame_valid=0; the drop is asynchronous, before the next clk edge.
- Basic frame, WIDTH=4: sync=1 with d=1, then in_valid samples d=2,3,4 on consecutive cycles -> after the 4th edge y0=1, y1=2, y2=3, y3=4, frame_valid=1 for exactly one cycle, sel=0.
- Stall: same frame with in_valid=0 for 3 cycles between samples 2 and 3 -> sel holds at 2 during the gap; same outputs; frame_valid pulses once.
- Realign: send 2 samples (A,B), then sync+d=9 followed by 10,11,12 -> y=9,10,11,12; no frame_valid before it. With DEMUX_SYNC_ERR_EN, sync_err=1 for one cycle after the sync edge.
- Continuous stream: 12 back-to-back samples 0..11 -> three frame_valid pulses 4 cycles apart, last frame y=8,9,10,11; outputs hold after the stream stops.
- Sync-only: sync=1, in_valid=0 at sel=2 -> sel=0 next cycle, y unchanged, no frame_valid (sync_err=1 if enabled).
